// File: rtl/twp_master.sv
// rtl/twp_master.sv - Two-Wire Protocol initiator: request port to SCL/SDA frames
module twp_master #(
    parameter int HALF_PERIOD = 2,
    parameter int GAP_BITS    = 2,
    parameter int TIMEOUT     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        cmd,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        SCL,
    inout  wire         SDA
);
    localparam int DW   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int CMAX = (GAP_BITS > TIMEOUT) ? ((GAP_BITS > 16) ? GAP_BITS : 16)
                                               : ((TIMEOUT > 16) ? TIMEOUT : 16);
    localparam int CW   = $clog2(CMAX + 1);

    // LAUNCH waits for the first scl_fall after accept; HOLD keeps SDA
    // released until the scl_fall that starts the gap.
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LAUNCH = 4'd1;
    localparam logic [3:0] S_START  = 4'd2;
    localparam logic [3:0] S_CMD    = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_WDATA  = 4'd5;
    localparam logic [3:0] S_WAIT   = 4'd6;
    localparam logic [3:0] S_RDATA  = 4'd7;
    localparam logic [3:0] S_HOLD   = 4'd8;
    localparam logic [3:0] S_GAP    = 4'd9;

    logic [DW-1:0] div_q;
    logic          scl_q;
    logic          tick, scl_rise, scl_fall;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   sh_q, sh_d;
    logic [15:0]   rsh_q, rsh_d;
    logic          cmd_q, cmd_d;
    logic          sda_q, sda_d;
    logic          oe_q, oe_d;
    logic          to_q, to_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          sda_in;

    assign tick     = (div_q == DW'(HALF_PERIOD - 1));
    assign scl_rise = tick && !scl_q;
    assign scl_fall = tick && scl_q;
    assign sda_in   = SDA;
    assign SDA      = oe_q ? sda_q : 1'bz;

    assign SCL   = scl_q;
    assign ready = ready_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;

    // Free-running SCL divider, active in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            scl_q <= 1'b0;
        end else if (tick) begin
            div_q <= '0;
            scl_q <= ~scl_q;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Frame sequencing: SDA changes on scl_fall, sampling on scl_rise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rsh_d   = rsh_q;
        cmd_d   = cmd_q;
        sda_d   = sda_q;
        oe_d    = oe_q;
        to_d    = to_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req && ready_q) begin
                state_d = S_LAUNCH;
                cmd_d   = cmd;
                sh_d    = {wdata, addr};
                rsh_d   = '0;
                to_d    = 1'b0;
            end
            S_LAUNCH: if (scl_fall) begin
                sda_d   = 1'b0;
                state_d = S_START;
            end
            S_START: if (scl_fall) begin
                sda_d   = cmd_q;
                state_d = S_CMD;
            end
            S_CMD: if (scl_fall) begin
                sda_d   = sh_q[0];
                sh_d    = sh_q >> 1;
                cnt_d   = '0;
                state_d = S_ADDR;
            end
            S_ADDR: if (scl_fall) begin
                if (cnt_q == CW'(7)) begin
                    cnt_d = '0;
                    if (cmd_q) begin
                        sda_d   = sh_q[0];
                        sh_d    = sh_q >> 1;
                        state_d = S_WDATA;
                    end else begin
                        oe_d    = 1'b0;
                        sda_d   = 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    sda_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WDATA: if (scl_fall) begin
                if (cnt_q == CW'(15)) begin
                    sda_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    sda_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: if (scl_rise) begin
                if (!sda_in) begin
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RDATA: if (scl_rise) begin
                rsh_d = {sda_in, rsh_q[15:1]};
                if (cnt_q == CW'(15)) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: if (scl_fall) begin
                oe_d    = 1'b1;
                sda_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: if (scl_fall) begin
                if (cnt_q == CW'(GAP_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = to_q;
                    rdata_d = to_q ? 16'h0000 : rsh_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            rsh_q   <= '0;
            cmd_q   <= 1'b0;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
            to_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rsh_q   <= rsh_d;
            cmd_q   <= cmd_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
            to_q    <= to_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_twp_master.sv
// tb/tb_twp_master.sv - scoreboard bench for twp_master with a TWP slave model
module tb_twp_master;
    localparam int HP = 2;
    localparam int GB = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        cmd = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [15:0] wdata = 16'h0000;
    logic        ready, done, err, SCL;
    logic [15:0] rdata;
    wire         SDA;

    logic        sl_oe = 1'b0;
    logic        sl_bit = 1'b1;
    assign SDA = sl_oe ? sl_bit : 1'bz;
    pullup (SDA);

    always #5 clk = ~clk;

    twp_master #(.HALF_PERIOD(HP), .GAP_BITS(GB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err), .SCL(SCL), .SDA(SDA)
    );

    int n_vec = 0;
    int n_fail = 0;
    int done_cnt = 0;

    logic [24:0] exp_frm[$];   // {cmd, addr, wdata or 0 for reads}
    logic [17:0] exp_res[$];   // {is_read, err, rdata}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave model: decodes frames on SCL rise, drives read data on SCL fall.
    logic [15:0] mem [256];
    logic        silent = 1'b0;
    int          sl_st = 0;
    int          sl_n = 0;
    int          idle_cnt = 1000;
    int          tcnt = 0;
    logic        f_cmd = 1'b0;
    logic [7:0]  f_addr = 8'h00;
    logic [15:0] f_wd = 16'h0000;
    logic [15:0] rd_word = 16'h0000;

    task automatic check_frame(input logic [24:0] got);
        if (exp_frm.size() == 0) begin
            chk("unexpected_frame", {7'd0, got}, 32'hFFFF_FFFF);
        end else begin
            chk("frame", {7'd0, got}, {7'd0, exp_frm.pop_front()});
        end
    endtask

    // Slave decoder and read-data driver
    always @(posedge SCL or negedge SCL or posedge reset) begin
        if (reset) begin
            sl_st = 0;
            sl_oe = 1'b0;
            idle_cnt = 1000;
        end else if (SCL) begin
            case (sl_st)
                0: if (SDA === 1'b0) begin
                    chk("gap_before_start", {31'd0, idle_cnt >= GB}, 32'd1);
                    sl_st = 1;
                end else begin
                    idle_cnt++;
                end
                1: begin
                    f_cmd = SDA;
                    sl_n = 0;
                    sl_st = 2;
                end
                2: begin
                    f_addr[sl_n] = SDA;
                    sl_n++;
                    if (sl_n == 8) begin
                        sl_n = 0;
                        if (f_cmd) begin
                            sl_st = 3;
                        end else begin
                            check_frame({1'b0, f_addr, 16'h0000});
                            rd_word = mem[f_addr];
                            tcnt = 0;
                            sl_st = 4;
                        end
                    end
                end
                3: begin
                    f_wd[sl_n] = SDA;
                    sl_n++;
                    if (sl_n == 16) begin
                        check_frame({1'b1, f_addr, f_wd});
                        mem[f_addr] = f_wd;
                        idle_cnt = 0;
                        sl_st = 0;
                    end
                end
                default: ;
            endcase
        end else if (sl_st == 4) begin
            tcnt++;
            if (silent) begin
                if (tcnt == TO + 1) begin
                    idle_cnt = 0;
                    sl_st = 0;
                end
            end else if (tcnt == 4) begin
                sl_oe = 1'b1;
                sl_bit = 1'b0;
            end else if (tcnt >= 5 && tcnt <= 20) begin
                sl_bit = rd_word[tcnt-5];
            end else if (tcnt == 21) begin
                sl_oe = 1'b0;
                idle_cnt = 0;
                sl_st = 0;
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_res.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_res.pop_front();
                chk("err", {31'd0, err}, {31'd0, e[16]});
                if (e[17]) chk("rdata", {16'd0, rdata}, {16'd0, e[15:0]});
                chk("ready_with_done", {31'd0, ready}, 32'd1);
            end
        end
    end

    task automatic issue(input logic c, input logic [7:0] a, input logic [15:0] d,
                         input logic ee, input logic [15:0] er);
        int k = 0;
        while (ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("ready_timeout", 32'd0, 32'd1);
        req = 1'b1; cmd = c; addr = a; wdata = d;
        exp_frm.push_back({c, a, c ? d : 16'h0000});
        exp_res.push_back({~c, ee, er});
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (k >= 600) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        int dc;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'd0, SCL}, 32'd0);
        chk("rst_sda", {31'd0, SDA}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, ready}, 32'd1);

        // Plain write
        issue(1'b1, 8'h3C, 16'hA5F0, 1'b0, 16'h0000);
        wait_done();
        @(negedge clk);

        // Read with nominal turnaround
        mem[8'h55] = 16'h1234;
        issue(1'b0, 8'h55, 16'h0000, 1'b0, 16'h1234);
        wait_done();
        @(negedge clk);

        // Read with no slave answer
        silent = 1'b1;
        issue(1'b0, 8'h66, 16'h0000, 1'b1, 16'h0000);
        wait_done();
        @(negedge clk);
        silent = 1'b0;

        // Back-to-back write then read, read issued in the done cycle
        issue(1'b1, 8'h10, 16'hBEEF, 1'b0, 16'h0000);
        wait_done();
        issue(1'b0, 8'h10, 16'h0000, 1'b0, 16'hBEEF);
        wait_done();
        @(negedge clk);

        // req held high while busy with a different address
        dc = done_cnt;
        issue(1'b1, 8'h20, 16'h1111, 1'b0, 16'h0000);
        req = 1'b1; addr = 8'h21; wdata = 16'h2222;
        repeat (30) @(negedge clk);
        req = 1'b0;
        wait_done();
        @(negedge clk);
        chk("held_req_one_done", done_cnt - dc, 32'd1);

        // Reset in the middle of WDATA bit 7
        mem[8'h05] = 16'h0000;
        issue(1'b1, 8'h05, 16'h1357, 1'b0, 16'h0000);
        k = 0;
        while (!(sl_st == 3 && sl_n == 7) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) chk("reach_wdata7", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        dc = done_cnt;
        reset = 1'b1;
        #1;
        chk("midrst_scl", {31'd0, SCL}, 32'd0);
        chk("midrst_sda", {31'd0, SDA}, 32'd1);
        exp_frm.delete();
        exp_res.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("no_done_after_abort", done_cnt - dc, 32'd0);
        chk("aborted_write_not_stored", {16'd0, mem[8'h05]}, 32'd0);

        issue(1'b1, 8'h01, 16'h00FF, 1'b0, 16'h0000);
        wait_done();
        issue(1'b0, 8'h01, 16'h0000, 1'b0, 16'h00FF);
        wait_done();
        repeat (20) @(negedge clk);

        chk("frames_left", exp_frm.size(), 32'd0);
        chk("results_left", exp_res.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/twp_master.md
Name: twp_master

Overview:
- Two-Wire Protocol (TWP) initiator. It converts single-word read/write requests from a local request port into serial TWP frames on SCL/SDA. It is the counterpart of the TWP slave in the register-access target.
- It generates SCL from clk, drives the command, address and write-data bits, then releases SDA to receive read data.
- One request is in flight at a time.

Parameters:
HALF_PERIOD, 2, clk cycles per SCL half period (min 1); SCL period = 2*HALF_PERIOD clk
GAP_BITS, 2, SCL periods of SDA=1 idle after every frame before the next start
TIMEOUT, 8, SCL periods to wait for slave start-of-data (SDA=0) on reads

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  1  request valid; accepted when req && ready
cmd  in  1  1 = write, 0 = read; sampled at accept
addr  in  8  register address; sampled at accept
wdata  in  16  write data; sampled at accept
ready  out  1  high in IDLE only
done  out  1  one-clk pulse when a frame finishes
rdata  out  16  read data; valid with done for reads, held until next done
err  out  1  read timeout flag; valid with done, held until next done
SCL  out  1  TWP clock, free-running
SDA  inout  1  TWP data; master drives 0/1 or releases (z)

Behaviour:
- Reset values: SCL=0, SDA driven 1, ready=0 (goes to 1 in IDLE on the first clk after reset), done=0, rdata=0, err=0, all counters 0, state IDLE.
- SCL generation:
  - Divider counter toggles SCL every HALF_PERIOD clk cycles, in every state including IDLE.
  - scl_rise / scl_fall are the one-clk ticks on which SCL goes 1 / 0.
- Bit timing:
  - Master updates SDA only on scl_fall ticks.
  - Master samples SDA only on scl_rise ticks.
  - Each TWP bit occupies one SCL period, falling edge to falling edge.
- Bit order: addr and data are sent LSB first (bit0 first).
- Accept:
  - In IDLE, on req=1, latch cmd/addr/wdata and deassert ready.
  - The first frame bit goes out at the next scl_fall.
  - req while not ready is ignored (no queueing).
- Write frame, per SCL bit, driven:
  - START: 0
  - CMD: 1
  - ADDR: 8 bits
  - WDATA: 16 bits
  - GAP: 1 for GAP_BITS bits
  - DONE: done=1 for one clk, err=0, then IDLE
  - Total SCL bits = 26 + GAP_BITS.
- Read frame:
  - START: drive 0. CMD: drive 0. ADDR: drive 8 bits.
  - TURN: release SDA (z) from the scl_fall ending ADDR bit 7.
  - WAIT: on each scl_rise sample SDA. The first sample of 0 is the slave start-of-data marker; go to RDATA. The nominal slave has 3 turnaround bits before the marker (fourth sample is 0); the master must not depend on that count.
  - RDATA: capture 16 bits on 16 consecutive scl_rise ticks into a shift register, bit0 first. SDA stays released.
  - GAP: drive 1 for GAP_BITS bits from the scl_fall after the last capture.
  - DONE: rdata=captured word, err=0, done pulse.
- Timeout:
  - If TIMEOUT scl_rise samples in WAIT are all nonzero, set err=1 and rdata=16'h0000.
  - Then run GAP (SDA driven 1), then pulse done.
- SDA direction:
  - Driven in IDLE, START, CMD, ADDR, WDATA, GAP.
  - Released (z) in TURN/WAIT/RDATA.
  - Master and slave must never both drive SDA.
- Bit counter:
  - Counts per phase: 8 for ADDR, 16 for WDATA/RDATA, GAP_BITS, TIMEOUT.
  - Clears on every phase transition; no wrap beyond phase length.
- done and ready: done and ready both assert on the same clk (DONE to IDLE). A new req may be accepted on the clk after done.
- Reset mid-frame: async reset forces IDLE, SDA driven 1, SCL=0 immediately. The partial frame is abandoned; no done pulse.
- HALF_PERIOD=1: SCL toggles every clk. Rise and fall ticks alternate each clk. All rules above hold.

Test Plan:
- Write: req, cmd=1, addr=8'h3C, wdata=16'hA5F0, HALF_PERIOD=2 -> SDA bits 0,1,0,0,1,1,1,1,0,0 then 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1, 2 gap bits of 1, done=1 one clk, err=0, ready=1.
- Read, slave model marker after 3 turnaround bits, data 16'h1234 -> SDA z from ADDR end; done with rdata=16'h1234, err=0; frame = 2+8+3+1+16+GAP_BITS bits.
- Read, slave never drives (SDA pulled high) -> after 8 WAIT samples: err=1, rdata=16'h0000, done pulse, ready=1.
- Back-to-back: write 0x10=16'hBEEF then read 0x10 issued the clk after done, against the TPA slave -> read returns 16'hBEEF; second START appears only after ≥2 gap bits of SDA=1.
- req held while busy with different addr -> ignored; only the first transaction appears on SDA; one done.
- Assert reset mid-WDATA (bit 7) -> SCL=0, SDA=1 within the same cycle, no done; a subsequent write to 0x01 completes normally.
